// File: rtl/rf_pkg.sv
// Shared constants and types for the integer register file and its dump sequencer.
package rf_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_SP     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } rf_dump_state_t;

endpackage

// File: rtl/rf_dump_seq.sv
// End-of-program dump sequencer: walks every register index out over a
// valid/ready channel once, then parks in DONE until reset. The register
// value for the next index is looked up by the parent through fetch_addr.
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      call_for_print,
  input  logic                      dump_ready,
  input  logic [BUS_DATA_WIDTH-1:0] fetch_data,
  output logic [REG_ADDR_W-1:0]     fetch_addr,
  output logic                      dump_valid,
  output logic [REG_ADDR_W-1:0]     dump_idx,
  output logic [BUS_DATA_WIDTH-1:0] dump_data,
  output logic                      dump_done,
  output logic                      busy
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  rf_dump_state_t state, next_state;

  logic accept;

  assign accept     = (state == DUMP) && dump_ready;
  assign fetch_addr = dump_idx + 1'b1;
  assign dump_valid = (state == DUMP);
  assign busy       = (state == DUMP);
  assign dump_done  = (state == DONE);

  // State register; DONE is only left through reset.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; a dropped request mid-dump does not stop the walk.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (call_for_print) next_state = DUMP;
      DUMP:    if (accept && (dump_idx == LAST_IDX)) next_state = DONE;
      DONE:    next_state = DONE;
      default: next_state = IDLE;
    endcase
  end

  // Presented entry: held while stalled, advanced with a fresh lookup on acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if ((state == IDLE) && call_for_print) begin
      dump_idx  <= '0;
      dump_data <= '0;
    end else if (accept && (dump_idx != LAST_IDX)) begin
      dump_idx  <= fetch_addr;
      dump_data <= fetch_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// Integer register file: 32 entries with x0 hardwired to zero, two
// combinational read ports with write-through bypass, and an end-of-program
// dump channel driven by rf_dump_seq.
module register_file
  import rf_pkg::*;
#(
  parameter int                        BUS_DATA_WIDTH = 64,
  parameter logic [BUS_DATA_WIDTH-1:0] SP_INIT        = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      write_en,
  input  logic [REG_ADDR_W-1:0]     rd_addr,
  input  logic [BUS_DATA_WIDTH-1:0] wr_data,
  input  logic [REG_ADDR_W-1:0]     rs1_addr,
  input  logic [REG_ADDR_W-1:0]     rs2_addr,
  output logic [BUS_DATA_WIDTH-1:0] rs1_data,
  output logic [BUS_DATA_WIDTH-1:0] rs2_data,
  input  logic                      call_for_print,
  output logic                      dump_valid,
  input  logic                      dump_ready,
  output logic [REG_ADDR_W-1:0]     dump_idx,
  output logic [BUS_DATA_WIDTH-1:0] dump_data,
  output logic                      dump_done,
  output logic                      busy
);

  logic [BUS_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [REG_ADDR_W-1:0]     fetch_addr;
  logic [BUS_DATA_WIDTH-1:0] fetch_data;

  // Read with x0 forced to zero and the in-flight write forwarded.
  function automatic logic [BUS_DATA_WIDTH-1:0] bypass_read(input logic [REG_ADDR_W-1:0] addr);
    if (addr == '0)                        return '0;
    else if (write_en && (rd_addr == addr)) return wr_data;
    else                                   return regs[addr];
  endfunction

  // Register array; reset wins over a simultaneous write, x0 writes are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == REG_SP) ? SP_INIT : '0;
      end
    end else if (write_en && (rd_addr != '0)) begin
      regs[rd_addr] <= wr_data;
    end
  end

  // Decode read ports and the dump lookahead share the same bypass rule.
  always_comb begin
    rs1_data   = bypass_read(rs1_addr);
    rs2_data   = bypass_read(rs2_addr);
    fetch_data = bypass_read(fetch_addr);
  end

  rf_dump_seq #(
    .BUS_DATA_WIDTH(BUS_DATA_WIDTH)
  ) u_dump_seq (
    .clk           (clk),
    .reset         (reset),
    .call_for_print(call_for_print),
    .dump_ready    (dump_ready),
    .fetch_data    (fetch_data),
    .fetch_addr    (fetch_addr),
    .dump_valid    (dump_valid),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data),
    .dump_done     (dump_done),
    .busy          (busy)
  );

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: randomized and directed traffic checked every
// cycle against an array-based reference model of the register file and dump.
module tb_register_file;

  localparam int W = 64;
  localparam logic [W-1:0] SP_VAL = 64'h0000_0000_8000_0FF0;

  localparam int PH_IDLE = 0;
  localparam int PH_DUMP = 1;
  localparam int PH_DONE = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         write_en = 1'b0;
  logic [4:0]   rd_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic [4:0]   rs1_addr = '0;
  logic [4:0]   rs2_addr = '0;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic         call_for_print = 1'b0;
  logic         dump_valid;
  logic         dump_ready = 1'b0;
  logic [4:0]   dump_idx;
  logic [W-1:0] dump_data;
  logic         dump_done;
  logic         busy;

  int vectors = 0;
  int miscompares = 0;

  logic [W-1:0] m_regs [32];
  int           m_phase;
  int           m_beat;
  logic [W-1:0] m_snap;

  logic [4:0]   acc_idx_q [$];
  logic [W-1:0] acc_data_q [$];

  always #5 clk = ~clk;

  register_file #(
    .BUS_DATA_WIDTH(W),
    .SP_INIT       (SP_VAL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_en      (write_en),
    .rd_addr       (rd_addr),
    .wr_data       (wr_data),
    .rs1_addr      (rs1_addr),
    .rs2_addr      (rs2_addr),
    .rs1_data      (rs1_data),
    .rs2_data      (rs2_data),
    .call_for_print(call_for_print),
    .dump_valid    (dump_valid),
    .dump_ready    (dump_ready),
    .dump_idx      (dump_idx),
    .dump_data     (dump_data),
    .dump_done     (dump_done),
    .busy          (busy)
  );

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void resetModel();
    foreach (m_regs[i]) m_regs[i] = '0;
    m_regs[2] = SP_VAL;
    m_phase   = PH_IDLE;
    m_beat    = 0;
    m_snap    = '0;
  endfunction

  function automatic logic [W-1:0] modelRead(input logic [4:0] a);
    if (a == 0)                       return '0;
    if (write_en && (rd_addr == a))   return wr_data;
    return m_regs[a];
  endfunction

  // Advance the model by one clock edge using the inputs held during the cycle.
  function automatic void updateModel();
    if (reset) begin
      resetModel();
      return;
    end
    if (write_en && (rd_addr != 0)) m_regs[rd_addr] = wr_data;
    case (m_phase)
      PH_IDLE: if (call_for_print) begin
        m_phase = PH_DUMP;
        m_beat  = 0;
        m_snap  = '0;
      end
      PH_DUMP: if (dump_ready) begin
        if (m_beat == 31) m_phase = PH_DONE;
        else begin
          m_beat = m_beat + 1;
          m_snap = m_regs[m_beat];
        end
      end
      default: ;
    endcase
  endfunction

  // One clock cycle: check combinational and dump outputs mid-cycle, then clock.
  task automatic applyStimulus();
    #3;
    checkOutput("rs1_data", rs1_data, modelRead(rs1_addr));
    checkOutput("rs2_data", rs2_data, modelRead(rs2_addr));
    checkOutput("dump_valid", W'(dump_valid), W'(m_phase == PH_DUMP));
    checkOutput("busy", W'(busy), W'(m_phase == PH_DUMP));
    checkOutput("dump_done", W'(dump_done), W'(m_phase == PH_DONE));
    checkOutput("dump_idx", W'(dump_idx), W'(m_beat));
    checkOutput("dump_data", dump_data, m_snap);
    if (dump_valid && dump_ready) begin
      acc_idx_q.push_back(dump_idx);
      acc_data_q.push_back(dump_data);
    end
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic randomTraffic();
    write_en = 1'($urandom_range(0, 1));
    rd_addr  = 5'($urandom_range(0, 31));
    wr_data  = {$urandom, $urandom};
    rs1_addr = 5'($urandom_range(0, 31));
    rs2_addr = (($urandom_range(0, 3)) == 0) ? rd_addr : 5'($urandom_range(0, 31));
  endtask

  task automatic doReset();
    reset = 1'b1;
    write_en = 1'b0;
    call_for_print = 1'b0;
    dump_ready = 1'b0;
    applyStimulus();
    applyStimulus();
    reset = 1'b0;
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) begin
      write_en = 1'b1;
      rd_addr  = 5'(i);
      wr_data  = W'(i * 16);
      rs1_addr = 5'(i);
      rs2_addr = 5'($urandom_range(0, 31));
      applyStimulus();
    end
    write_en = 1'b0;
  endtask

  task automatic checkBeatOrder(input string tag);
    checkOutput({tag, "_count"}, W'(acc_idx_q.size()), W'(32));
    foreach (acc_idx_q[i]) checkOutput({tag, "_idx"}, W'(acc_idx_q[i]), W'(i));
  endtask

  initial begin
    int edges;
    resetModel();
    doReset();

    // Reset contents on every index through both ports.
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'(31 - i);
      applyStimulus();
    end
    rs1_addr = 5'd2;
    #3;
    checkOutput("sp_reset", rs1_data, SP_VAL);
    @(posedge clk);
    #1;

    // Write-through bypass, then the stored value.
    write_en = 1'b1; rd_addr = 5'd5; wr_data = 64'hDEAD_BEEF; rs1_addr = 5'd5; rs2_addr = 5'd3;
    #3;
    checkOutput("bypass_x5", rs1_data, 64'hDEAD_BEEF);
    applyStimulus();
    write_en = 1'b0;
    #3;
    checkOutput("stored_x5", rs1_data, 64'hDEAD_BEEF);
    applyStimulus();

    // x0 write is dropped.
    write_en = 1'b1; rd_addr = 5'd0; wr_data = 64'h1234; rs2_addr = 5'd0;
    applyStimulus();
    write_en = 1'b0;
    applyStimulus();

    // Random read/write traffic.
    for (int c = 0; c < 300; c++) begin
      randomTraffic();
      applyStimulus();
    end
    write_en = 1'b0;

    // Full-rate dump of a known pattern and its completion latency.
    $display("[TB] full-rate dump");
    doReset();
    preload();
    acc_idx_q.delete();
    acc_data_q.delete();
    call_for_print = 1'b1;
    dump_ready = 1'b1;
    applyStimulus();
    call_for_print = 1'b0;
    edges = 0;
    while (!dump_done && edges < 40) begin
      rs1_addr = 5'($urandom_range(0, 31));
      applyStimulus();
      edges++;
    end
    checkOutput("done_edges_after_request", W'(edges), W'(32));
    checkBeatOrder("full");
    foreach (acc_data_q[i]) checkOutput("full_data", acc_data_q[i], W'(i * 16));
    for (int c = 0; c < 3; c++) applyStimulus();

    // Stalling dump with concurrent writes; x7 written as beat 6 is accepted.
    $display("[TB] stalled dump");
    doReset();
    preload();
    acc_idx_q.delete();
    acc_data_q.delete();
    call_for_print = 1'b1;
    dump_ready = 1'b0;
    applyStimulus();
    edges = 0;
    while (m_phase != PH_DONE && edges < 400) begin
      call_for_print = 1'($urandom_range(0, 1));
      dump_ready = 1'($urandom_range(0, 1));
      randomTraffic();
      if (m_beat == 6 && dump_ready) begin
        write_en = 1'b1; rd_addr = 5'd7; wr_data = 64'hAA;
      end
      applyStimulus();
      edges++;
    end
    checkOutput("stall_dump_finished", W'(m_phase == PH_DONE), W'(1));
    checkBeatOrder("stall");
    if (acc_data_q.size() > 7) checkOutput("beat7_data", acc_data_q[7], 64'hAA);
    write_en = 1'b0;
    call_for_print = 1'b0;
    applyStimulus();

    // Reset in the middle of a dump.
    $display("[TB] reset mid-dump");
    doReset();
    preload();
    call_for_print = 1'b1;
    dump_ready = 1'b1;
    edges = 0;
    while (!(m_phase == PH_DUMP && m_beat == 10) && edges < 40) begin
      applyStimulus();
      edges++;
    end
    checkOutput("reached_idx10", W'(dump_idx), W'(10));
    reset = 1'b1;
    call_for_print = 1'b0;
    applyStimulus();
    reset = 1'b0;
    dump_ready = 1'b0;
    checkOutput("abort_valid", W'(dump_valid), W'(0));
    checkOutput("abort_busy", W'(busy), W'(0));
    checkOutput("abort_idx", W'(dump_idx), W'(0));
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i);
      rs2_addr = 5'($urandom_range(0, 31));
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
